// File: rtl/cf_spi_pkg.sv
// ============================================================================
// cf_spi_pkg : word size, idle word and SPI mode encodings shared with CF_SPI
// Rev 1.0
// ============================================================================
`default_nettype none

package cf_spi_pkg;

  localparam int         CF_SPI_DW        = 8;
  localparam logic [7:0] CF_SPI_IDLE_WORD = 8'hFF;

  // Mode number is {CPOL,CPHA}.
  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_e;

  function automatic logic mode_cpol(input spi_mode_e m);
    return m[1];
  endfunction

  function automatic logic mode_cpha(input spi_mode_e m);
    return m[0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/cf_spi_pin_sync.sv
// ============================================================================
// cf_spi_pin_sync : N-stage synchroniser with optional rise/fall pulses
// Rev 1.0
// ============================================================================
`default_nettype none

module cf_spi_pin_sync #(
  parameter int STAGES  = 2,
  parameter bit RST_VAL = 1'b0,
  parameter bit EDGES   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

  generate
    if (EDGES) begin : g_edges
      logic prev_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev_q <= RST_VAL;
        end else begin
          prev_q <= q_o;
        end
      end

      assign rise_o = q_o & ~prev_q;
      assign fall_o = ~q_o & prev_q;
    end else begin : g_no_edges
      assign rise_o = 1'b0;
      assign fall_o = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/cf_spi_target.sv
// ============================================================================
// cf_spi_target : oversampling SPI target, MSB-first, all four SPI modes
// Rev 1.0
// ============================================================================
`default_nettype none

module cf_spi_target
  import cf_spi_pkg::*;
#(
  parameter int            DW          = CF_SPI_DW,
  parameter int            SYNC_STAGES = 2,
  parameter logic [DW-1:0] IDLE_WORD   = DW'(CF_SPI_IDLE_WORD)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          CPOL,
  input  logic          CPHA,
  input  logic          sclk,
  input  logic          csb,
  input  logic          mosi,
  output logic          miso,
  output logic          miso_oe,
  input  logic [DW-1:0] tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic [DW-1:0] rx_data,
  output logic          rx_valid,
  input  logic          rx_rd,
  input  logic          clr_flags,
  output logic          ovr,
  output logic          udr,
  output logic          frm_err
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  logic sclk_s, sclk_rise, sclk_fall;
  logic csb_s, csb_rise, csb_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  cf_spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGES(1'b1)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(sclk),
    .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  // csb resets to "deselected" so miso_oe stays low until a real frame.
  cf_spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1), .EDGES(1'b1)) u_sync_csb (
    .clk(clk), .rst_n(rst_n), .d_i(csb),
    .q_o(csb_s), .rise_o(csb_rise), .fall_o(csb_fall)
  );

  cf_spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0), .EDGES(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d_i(mosi),
    .q_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  logic [SYNC_STAGES-1:0] settle_q;
  logic                   armed_q, armed_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DW-1:0]          rx_shift_q, rx_shift_d;
  logic [DW-1:0]          rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic [DW-1:0]          tx_shift_q, tx_shift_d;
  logic [DW-1:0]          hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic                   ovr_q, ovr_d, udr_q, udr_d, frm_q, frm_d;

  logic active, lead_edge, trail_edge, sample_edge, drive_edge;
  logic word_done, load, tx_write;

  // A frame only starts after csb has been seen high with a settled chain,
  // so a reset in mid-frame waits for the next genuine csb falling edge.
  assign armed_d     = armed_q | (settle_q[SYNC_STAGES-1] & csb_s);
  assign active      = armed_q & ~csb_s;
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = active & (CPHA ? trail_edge : lead_edge);
  assign drive_edge  = active & (CPHA ? lead_edge : trail_edge);
  assign word_done   = sample_edge & (cnt_q == CW'(DW-1));
  assign load        = (drive_edge & (cnt_q == '0)) | (armed_q & ~CPHA & csb_fall);
  assign tx_write    = tx_valid & ~hold_full_q;

  always_comb begin
    cnt_d       = cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q & ~rx_rd;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    ovr_d       = ovr_q;
    udr_d       = udr_q;
    frm_d       = frm_q;

    if (sample_edge) begin
      rx_shift_d = {rx_shift_q[DW-2:0], mosi_s};
      cnt_d      = word_done ? '0 : cnt_q + CW'(1);
    end

    if (word_done) begin
      rx_data_d  = {rx_shift_q[DW-2:0], mosi_s};
      rx_valid_d = 1'b1;
      if (rx_valid_q && !rx_rd) begin
        ovr_d = 1'b1;
      end
    end

    if (armed_q && csb_rise) begin
      cnt_d      = '0;
      rx_shift_d = '0;
      if (cnt_q != '0) begin
        frm_d = 1'b1;
      end
    end

    // The load consumes the old holding content; a same-cycle write refills it.
    if (load) begin
      if (hold_full_q) begin
        tx_shift_d = hold_q;
      end else begin
        tx_shift_d = IDLE_WORD;
        udr_d      = 1'b1;
      end
      hold_full_d = 1'b0;
    end else if (drive_edge) begin
      tx_shift_d = {tx_shift_q[DW-2:0], 1'b0};
    end

    if (tx_write) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    if (clr_flags) begin
      ovr_d = 1'b0;
      udr_d = 1'b0;
      frm_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_q    <= '0;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ovr_q       <= 1'b0;
      udr_q       <= 1'b0;
      frm_q       <= 1'b0;
    end else begin
      settle_q    <= {settle_q[SYNC_STAGES-2:0], 1'b1};
      armed_q     <= armed_d;
      cnt_q       <= cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ovr_q       <= ovr_d;
      udr_q       <= udr_d;
      frm_q       <= frm_d;
    end
  end

  assign miso     = tx_shift_q[DW-1];
  assign miso_oe  = ~csb_s;
  assign tx_ready = ~hold_full_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign ovr      = ovr_q;
  assign udr      = udr_q;
  assign frm_err  = frm_q;

endmodule

`default_nettype wire

// File: tb/tb_cf_spi_target.sv
// ============================================================================
// tb_cf_spi_target : directed bench, bench-side SPI master drives the target
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cf_spi_target;
  import cf_spi_pkg::*;

  localparam int DW = 8;
  localparam int HP = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          CPOL = 1'b0;
  logic          CPHA = 1'b0;
  logic          sclk = 1'b0;
  logic          csb = 1'b1;
  logic          mosi = 1'b0;
  logic          miso, miso_oe;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_rd = 1'b0;
  logic          clr_flags = 1'b0;
  logic          ovr, udr, frm_err;

  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] feed_q[$];
  logic [DW-1:0] mi, mi2, mi3;
  spi_mode_e     modes[3];

  always #5 clk = ~clk;

  cf_spi_target #(.DW(DW), .SYNC_STAGES(2), .IDLE_WORD(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .CPOL(CPOL), .CPHA(CPHA),
    .sclk(sclk), .csb(csb), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_rd(rx_rd),
    .clr_flags(clr_flags), .ovr(ovr), .udr(udr), .frm_err(frm_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clk step; also advances the TX feeder when the target took a word.
  task automatic tick();
    logic acc;
    acc = tx_valid && tx_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      if (feed_q.size() > 0) tx_data = feed_q.pop_front();
      else tx_valid = 1'b0;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_feed();
    tx_data  = feed_q.pop_front();
    tx_valid = 1'b1;
  endtask

  task automatic pulse_rd();
    rx_rd = 1'b1; tick(); rx_rd = 1'b0; tick();
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1; tick(); clr_flags = 1'b0; tick();
  endtask

  task automatic set_mode(input spi_mode_e m);
    CPOL = mode_cpol(m);
    CPHA = mode_cpha(m);
    sclk = CPOL;
    ticks(HP);
  endtask

  task automatic frame_start();
    csb = 1'b0; ticks(HP);
  endtask

  task automatic frame_end();
    csb = 1'b1; ticks(HP);
  endtask

  // Master side: shift out the top nbits of mo, capture miso into mi.
  task automatic xfer(input logic [DW-1:0] mo, input int nbits, output logic [DW-1:0] mi_o);
    mi_o = '0;
    for (int i = DW-1; i >= DW-nbits; i--) begin
      if (!CPHA) begin
        mosi = mo[i]; ticks(HP);
        sclk = ~CPOL; mi_o[i] = miso; ticks(HP);
        sclk = CPOL;
      end else begin
        sclk = ~CPOL; mosi = mo[i]; ticks(HP);
        sclk = CPOL; mi_o[i] = miso; ticks(HP);
      end
    end
    if (!CPHA) ticks(HP);
  endtask

  initial begin
    modes[0] = MODE1; modes[1] = MODE2; modes[2] = MODE3;

    // Reset state
    ticks(3);
    rst_n = 1'b1;
    ticks(4);
    check("rst_miso", 32'(miso), 32'h0);
    check("rst_miso_oe", 32'(miso_oe), 32'h0);
    check("rst_tx_ready", 32'(tx_ready), 32'h1);
    check("rst_rx_data", 32'(rx_data), 32'h0);
    check("rst_rx_valid", 32'(rx_valid), 32'h0);
    check("rst_flags", 32'({ovr, udr, frm_err}), 32'h0);

    // Mode 0: two bytes in one frame, only the first has TX data
    set_mode(MODE0);
    feed_q.push_back(8'hA5); start_feed(); ticks(HP);
    check("m0_tx_ready_full", 32'(tx_ready), 32'h0);
    frame_start();
    check("m0_miso_oe", 32'(miso_oe), 32'h1);
    xfer(8'h35, DW, mi);
    check("m0_rx0", 32'(rx_data), 32'h35);
    check("m0_rx0_valid", 32'(rx_valid), 32'h1);
    check("m0_mi0", 32'(mi), 32'hA5);
    pulse_rd();
    check("m0_rd_clear", 32'(rx_valid), 32'h0);
    xfer(8'h93, DW, mi);
    frame_end();
    check("m0_rx1", 32'(rx_data), 32'h93);
    check("m0_rx1_valid", 32'(rx_valid), 32'h1);
    check("m0_mi1", 32'(mi), 32'hFF);
    check("m0_udr", 32'(udr), 32'h1);
    check("m0_ovr_frm", 32'({ovr, frm_err}), 32'h0);
    pulse_rd();

    // Modes 1..3: C3 out, 5A back, no flags
    for (int k = 0; k < 3; k++) begin
      pulse_clr();
      set_mode(modes[k]);
      feed_q.push_back(8'h5A);
      if (!CPHA) feed_q.push_back(8'h5A);
      start_feed(); ticks(HP);
      frame_start();
      xfer(8'hC3, DW, mi);
      frame_end();
      check($sformatf("mode%0d_rx", modes[k]), 32'(rx_data), 32'hC3);
      check($sformatf("mode%0d_rx_valid", modes[k]), 32'(rx_valid), 32'h1);
      check($sformatf("mode%0d_mi", modes[k]), 32'(mi), 32'h5A);
      check($sformatf("mode%0d_flags", modes[k]), 32'({ovr, udr, frm_err}), 32'h0);
      pulse_rd();
    end

    // Overrun
    set_mode(MODE0);
    pulse_clr();
    frame_start();
    xfer(8'h11, DW, mi);
    xfer(8'h22, DW, mi);
    frame_end();
    check("ovr_rx", 32'(rx_data), 32'h22);
    check("ovr_set", 32'(ovr), 32'h1);
    pulse_clr();
    check("ovr_clr", 32'(ovr), 32'h0);
    pulse_rd();

    // Frame abort after 5 bits, then a full frame
    frame_start();
    xfer(8'hF0, 5, mi);
    frame_end();
    check("abort_frm", 32'(frm_err), 32'h1);
    check("abort_rx_valid", 32'(rx_valid), 32'h0);
    frame_start();
    xfer(8'h0F, DW, mi);
    frame_end();
    check("abort_next_rx", 32'(rx_data), 32'h0F);
    check("abort_next_valid", 32'(rx_valid), 32'h1);

    // Back-to-back TX over a 3-byte frame
    pulse_clr();
    set_mode(MODE1);
    feed_q.push_back(8'h01); feed_q.push_back(8'h02); feed_q.push_back(8'h03);
    start_feed(); ticks(HP);
    frame_start();
    xfer(8'h00, DW, mi);
    xfer(8'h00, DW, mi2);
    xfer(8'h00, DW, mi3);
    frame_end();
    check("b2b_mi0", 32'(mi), 32'h01);
    check("b2b_mi1", 32'(mi2), 32'h02);
    check("b2b_mi2", 32'(mi3), 32'h03);
    check("b2b_udr", 32'(udr), 32'h0);
    check("b2b_tx_ready", 32'(tx_ready), 32'h1);

    // Reset during bit 4, then a clean frame
    set_mode(MODE0);
    frame_start();
    xfer(8'h7E, 4, mi);
    check("pre_rst_oe", 32'(miso_oe), 32'h1);
    rst_n = 1'b0; ticks(3); rst_n = 1'b1; tick();
    check("mid_rst_miso", 32'(miso), 32'h0);
    check("mid_rst_miso_oe", 32'(miso_oe), 32'h0);
    check("mid_rst_tx_ready", 32'(tx_ready), 32'h1);
    check("mid_rst_rx_data", 32'(rx_data), 32'h0);
    check("mid_rst_rx_valid", 32'(rx_valid), 32'h0);
    check("mid_rst_flags", 32'({ovr, udr, frm_err}), 32'h0);
    frame_end();
    frame_start();
    xfer(8'h7E, DW, mi);
    frame_end();
    check("post_rst_rx", 32'(rx_data), 32'h7E);
    check("post_rst_valid", 32'(rx_valid), 32'h1);
    check("post_rst_frm", 32'({ovr, frm_err}), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cf_spi_target.md
Name: cf_spi_target

Overview:
- SPI target (slave) endpoint on the far end of the CF_SPI master's sclk/mosi/csb wires; consumes the serial stream and returns miso.
- Oversamples all SPI pins in the system clock domain, deserialises MSB-first bytes into an RX holding register and serialises bytes from a TX holding register.
- Used as the bench/SoC-side peer for master loopback and as an on-chip target for external masters.

Parameters:
- DW, 8, bits per SPI word
- SYNC_STAGES, 2, synchroniser flops per input pin (minimum 2)
- IDLE_WORD, 8'hFF, word shifted out when the TX holding register is empty

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- CPOL  in  1  SCLK idle level; static while csb low
- CPHA  in  1  0: sample on leading edge; 1: sample on trailing edge; static while csb low
- sclk  in  1  SPI clock, asynchronous
- csb  in  1  chip select, active low, asynchronous
- mosi  in  1  serial data in
- miso  out  1  serial data out
- miso_oe  out  1  miso output enable; equals synchronised csb inverted
- tx_data  in  DW  next word to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  TX holding register empty
- rx_data  out  DW  last received word
- rx_valid  out  1  rx_data holds an unread word
- rx_rd  in  1  pop rx_data; clears rx_valid next cycle
- clr_flags  in  1  clears all sticky flags
- ovr  out  1  sticky: word received while rx_valid=1
- udr  out  1  sticky: IDLE_WORD sent because TX holding register was empty
- frm_err  out  1  sticky: csb deasserted with bit count not 0

Behaviour:
- Reset values: miso=0, miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, ovr=udr=frm_err=0, bit counter=0, shift registers=0.
- sclk, csb and mosi each pass through SYNC_STAGES flops. Edges are detected by comparing the last synchronised value with its previous value.
- Required SCLK half-period is at least SYNC_STAGES+2 clk cycles. At the default this is 4 cycles, which corresponds to master clk_divider >= 4.
- Leading edge = sclk leaves CPOL; trailing edge = sclk returns to CPOL. Sample edge = leading if CPHA=0, trailing if CPHA=1. The other edge is the drive edge.
- Edges are ignored while synchronised csb=1.
- Sample edge: shift mosi into rx_shift LSB and increment the bit counter (0..DW-1, wraps).
- On the DW-th sample:
  - rx_data <= completed word, rx_valid <= 1 on the next clk.
  - If rx_valid was already 1 and rx_rd is not asserted in the same cycle, set ovr. The new word overwrites.
- rx_rd together with a completing word in the same cycle: the new word wins and rx_valid stays 1.
- TX load points:
  - CPHA=0: synchronised csb falling edge, and every drive edge where the bit counter is 0 after a completed word.
  - CPHA=1: the drive edge where the bit counter is 0.
- At a load point, tx_shift <= holding register if full, else IDLE_WORD and udr set. The holding register empties and tx_ready=1 on the next clk.
- Other drive edges: shift tx_shift left by one.
- miso always equals tx_shift MSB.
- Holding register accepts a word when tx_valid & tx_ready. A write and a load point in the same cycle: the load takes the old content and the new word fills the register.
- csb rising (synchronised):
  - bit counter and rx_shift are cleared; a partial word is discarded.
  - frm_err is set if the counter was not 0.
  - TX holding content is kept.
- A csb glitch shorter than SYNC_STAGES cycles is not guaranteed to be seen.
- clr_flags has priority over a same-cycle set event (flag is cleared).
- Asynchronous reset mid-frame returns everything to reset values. Resynchronisation starts at the next csb falling edge.

Decomposition:
- Package cf_spi_pkg: DW default, IDLE_WORD default, and SPI mode encodings (MODE0..MODE3 as {CPOL,CPHA}). These are shared with CF_SPI.
- One sub-module, cf_spi_pin_sync: an N-stage synchroniser with rise/fall pulse outputs, instantiated for sclk and csb, and for mosi without edge outputs.

Test Plan:
- Mode 0: CF_SPI at clk_divider=10 sends 0x35 then 0x93; target tx preloaded with 0xA5 -> rx_data=0x35 then 0x93, each with rx_valid; master receives 0xA5 then 0xFF; udr=1.
- Modes 1, 2, 3: master sends 0xC3 and target sends 0x5A -> both sides receive the exact byte in every mode; no flags set.
- Overrun: two words 0x11 and 0x22 with no rx_rd -> rx_data=0x22, ovr=1; clr_flags -> ovr=0.
- Frame abort: csb raised after 5 bits of 0xF0 -> frm_err=1, rx_valid unchanged; the next full frame 0x0F is received correctly.
- Back-to-back TX: tx_valid held with 0x01, 0x02, 0x03 written on each tx_ready over a 3-byte frame -> master receives 01 02 03 and udr stays 0.
- Reset mid-byte: rst_n low for 3 clk during bit 4 -> all outputs at reset values; the next frame 0x7E is received correctly.
